// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
// Contents:
//   fetch_state_e  - controller state (BOOT, FETCH, KILL, HELD), 2 bits
//   NOP_INSTR      - instruction shown on the IF/ID register after reset
//   PC_INC         - sequential PC increment
//   fetch_entry_t  - {pc, instr} pair carried by the fetch path
//   align_target() - clears the low two bits of a redirect/jump target
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    HELD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so targets lose their low two bits.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that returned from imem
// while ID was stalled on a load-use hazard.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load        - capture load_entry and mark the entry valid
//   clear       - drop the entry (has priority over load)
//   load_entry  - {pc, instr} to capture
//   entry       - captured {pc, instr}
//   valid       - entry holds a live instruction
module fetch_skid_buf
  import pc_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  // Holding register; clear wins so a redirect can discard a pending capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      entry <= load_entry;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: sequences the PC register, runs the imem req/ack
// handshake, resolves redirect / load-use / jump priority and owns the
// IF/ID fetch output register.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   pc_q_i                     - current PC register value
//   pc_next_o, pc_hold_o       - next PC and hold control for the PC register
//   imem_req_o, imem_addr_o    - fetch request and address (held until ack)
//   imem_ack_i, imem_rdata_i   - 1-cycle response strobe and instruction
//   redirect_ex_i/_target_i    - EX branch/jalr taken and its target
//   jump_id_i/_target_i        - ID jal resolved and its target
//   load_use_stall_i           - hazard unit stall request
//   if_id_flush_o, id_ex_flush_o - pipeline flushes (combinational)
//   fetch_valid_o/_pc_o/_instr_o - registered IF/ID outputs
//   state_o                    - controller state for debug
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_q_i,
  output logic [31:0] pc_next_o,
  output logic        pc_hold_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_ex_i,
  input  logic [31:0] redirect_ex_target_i,
  input  logic        jump_id_i,
  input  logic [31:0] jump_id_target_i,
  input  logic        load_use_stall_i,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_instr_o,
  output logic [1:0]  state_o
);

  localparam int CNT_W = $clog2(BOOT_CYCLES + 1);

  fetch_state_e state_q, state_d;
  logic [CNT_W-1:0] boot_cnt;
  logic             boot_done;
  logic [31:0]      tgt_q, tgt_d;
  logic             tgt_load;
  logic [31:0]      ex_tgt, jmp_tgt;

  logic         fetch_load, fetch_from_buf, fetch_kill;
  logic         buf_load, buf_clear, buf_valid;
  fetch_entry_t buf_entry;

  assign ex_tgt    = align_target(redirect_ex_target_i);
  assign jmp_tgt   = align_target(jump_id_target_i);
  assign boot_done = (boot_cnt == CNT_W'(BOOT_CYCLES - 1));
  assign state_o   = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic. A redirect or jump without a same-cycle ack must wait
  // in KILL for the stale request to drain, since req stays up until ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  if (boot_done) state_d = FETCH;
      FETCH: begin
        if (redirect_ex_i || (!load_use_stall_i && jump_id_i)) begin
          if (!imem_ack_i) state_d = KILL;
        end else if (load_use_stall_i && imem_ack_i) begin
          state_d = HELD;
        end
      end
      KILL:  if (imem_ack_i) state_d = FETCH;
      HELD:  if (redirect_ex_i || !load_use_stall_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Output logic: PC control, imem handshake, flushes and internal strobes.
  always_comb begin
    pc_hold_o      = 1'b1;
    pc_next_o      = pc_q_i;
    imem_req_o     = 1'b0;
    imem_addr_o    = pc_q_i;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    fetch_load     = 1'b0;
    fetch_from_buf = 1'b0;
    fetch_kill     = 1'b0;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    tgt_load       = 1'b0;
    tgt_d          = tgt_q;
    case (state_q)
      BOOT: begin
        pc_next_o = RESET_VECTOR;
        if (boot_done) pc_hold_o = 1'b0;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_ex_i) begin
          pc_next_o     = ex_tgt;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          fetch_kill    = 1'b1;
          if (imem_ack_i) begin
            pc_hold_o = 1'b0;
          end else begin
            tgt_load = 1'b1;
            tgt_d    = ex_tgt;
          end
        end else if (load_use_stall_i) begin
          if (imem_ack_i) buf_load = 1'b1;
        end else if (jump_id_i) begin
          pc_next_o     = jmp_tgt;
          if_id_flush_o = 1'b1;
          fetch_kill    = 1'b1;
          if (imem_ack_i) begin
            pc_hold_o = 1'b0;
          end else begin
            tgt_load = 1'b1;
            tgt_d    = jmp_tgt;
          end
        end else if (imem_ack_i) begin
          pc_hold_o  = 1'b0;
          pc_next_o  = pc_q_i + PC_INC;
          fetch_load = 1'b1;
        end else begin
          fetch_kill = 1'b1;
        end
      end
      KILL: begin
        imem_req_o = 1'b1;
        fetch_kill = 1'b1;
        if (redirect_ex_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          tgt_load      = 1'b1;
          tgt_d         = ex_tgt;
        end
        if (imem_ack_i) begin
          pc_hold_o = 1'b0;
          pc_next_o = redirect_ex_i ? ex_tgt : tgt_q;
        end
      end
      HELD: begin
        if (redirect_ex_i) begin
          buf_clear     = 1'b1;
          pc_hold_o     = 1'b0;
          pc_next_o     = ex_tgt;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          fetch_kill    = 1'b1;
        end else if (!load_use_stall_i) begin
          buf_clear      = 1'b1;
          fetch_from_buf = 1'b1;
          pc_hold_o      = 1'b0;
          pc_next_o      = buf_entry.pc + PC_INC;
        end
      end
      default: ;
    endcase
  end

  // Boot counter; stops at its terminal value so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             boot_cnt <= '0;
    else if (state_q == BOOT && !boot_done) boot_cnt <= boot_cnt + CNT_W'(1);
  end

  // Pending redirect target, applied once the killed request is acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tgt_q <= RESET_VECTOR;
    else if (tgt_load) tgt_q <= tgt_d;
  end

  fetch_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_entry ('{pc: pc_q_i, instr: imem_rdata_i}),
    .entry      (buf_entry),
    .valid      (buf_valid)
  );

  // IF/ID output register; pc/instr keep their last value when invalidated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_o <= 1'b0;
      fetch_pc_o    <= '0;
      fetch_instr_o <= NOP_INSTR;
    end else if (fetch_kill) begin
      fetch_valid_o <= 1'b0;
    end else if (fetch_load) begin
      fetch_valid_o <= 1'b1;
      fetch_pc_o    <= pc_q_i;
      fetch_instr_o <= imem_rdata_i;
    end else if (fetch_from_buf) begin
      fetch_valid_o <= buf_valid;
      fetch_pc_o    <= buf_entry.pc;
      fetch_instr_o <= buf_entry.instr;
    end
  end

endmodule
